// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch FSM encoding, reset PC and opcode defines
package fetch_unit_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} fetch_state_e;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM feeding decode
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc,
    input  logic        flush,
    output logic [31:0] pc_out,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        id_ready,
    output logic        misalign,
    output logic [31:0] retire_cnt
);
    fetch_state_e state, state_d;
    logic drop, drop_d, load, accept, capture;
    assign accept  = state == VALID && id_ready && !flush;
    assign load    = (flush && state != IDLE) || (state == VALID && id_ready);
    assign capture = state == WAIT && imem_rvalid && !drop && !flush;
    // drop marks a granted request whose response must be thrown away
    assign drop_d  = state == REQ  ? (drop || (flush && imem_gnt)) :
                     state == WAIT ? (!imem_rvalid && (drop || flush)) : drop;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = REQ;
            REQ:     state_d = imem_gnt ? WAIT : REQ;
            WAIT:    state_d = !imem_rvalid ? WAIT : (drop || flush) ? REQ : VALID;
            VALID:   state_d = (flush || id_ready) ? REQ : VALID;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        imem_req   = state == REQ;
        imem_addr  = pc_out;
        inst_valid = state == VALID;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out     <= RESET_PC;
            drop       <= 1'b0;
            retire_cnt <= '0;
            inst       <= '0;
            inst_pc    <= '0;
            misalign   <= 1'b0;
        end else begin
            pc_out     <= load ? {npc[31:2], 2'b00} : pc_out;
            drop       <= drop_d;
            retire_cnt <= retire_cnt + {31'd0, accept};
            inst       <= capture ? imem_rdata : inst;
            inst_pc    <= capture ? pc_out : inst_pc;
            misalign   <= load && npc[1:0] != 2'b00;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed check of fetch_unit plus reset-in-WAIT sequence
module tb_fetch_unit;
    typedef struct packed {
        logic        f;
        logic [31:0] npc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        e_mis;
        logic [31:0] e_cnt;
    } vec_t;
    localparam logic Z = 1'b0;
    localparam logic O = 1'b1;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] npc = '0;
    logic        flush = 1'b0;
    logic [31:0] pc_out;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        id_ready = 1'b0;
    logic        misalign;
    logic [31:0] retire_cnt;
    int          n_chk = 0;
    int          n_bad = 0;
    vec_t        vq[$];

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .npc(npc), .flush(flush), .pc_out(pc_out),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .id_ready(id_ready), .misalign(misalign), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic val, input logic [31:0] ins, input logic [31:0] ipc,
                           input logic mis, input logic [31:0] cnt);
        chk({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, req});
        chk({tag, " imem_addr"}, imem_addr, addr);
        chk({tag, " pc_out"}, pc_out, addr);
        chk({tag, " inst_valid"}, {31'd0, inst_valid}, {31'd0, val});
        chk({tag, " inst"}, inst, ins);
        chk({tag, " inst_pc"}, inst_pc, ipc);
        chk({tag, " misalign"}, {31'd0, misalign}, {31'd0, mis});
        chk({tag, " retire_cnt"}, retire_cnt, cnt);
    endtask

    initial begin
        //            f  npc         gnt rv rdata        rdy  req addr        val inst        ipc         mis cnt
        vq.push_back('{Z, 32'h0,     Z, Z, 32'h0,        Z,   Z, 32'h0,       Z, 32'h0,       32'h0,      Z, 32'd0});
        vq.push_back('{Z, 32'h0,     O, Z, 32'h0,        Z,   O, 32'h0,       Z, 32'h0,       32'h0,      Z, 32'd0});
        vq.push_back('{Z, 32'h0,     Z, O, 32'h13,       Z,   Z, 32'h0,       Z, 32'h0,       32'h0,      Z, 32'd0});
        vq.push_back('{Z, 32'h4,     Z, Z, 32'h0,        O,   Z, 32'h0,       O, 32'h13,      32'h0,      Z, 32'd0});
        vq.push_back('{Z, 32'h0,     O, Z, 32'h0,        Z,   O, 32'h4,       Z, 32'h13,      32'h0,      Z, 32'd1});
        vq.push_back('{Z, 32'h0,     Z, O, 32'h100093,   Z,   Z, 32'h4,       Z, 32'h13,      32'h0,      Z, 32'd1});
        for (int i = 0; i < 5; i++)
            vq.push_back('{Z, 32'h0, Z, Z, 32'h0,        Z,   Z, 32'h4,       O, 32'h100093,  32'h4,      Z, 32'd1});
        vq.push_back('{Z, 32'h8,     Z, Z, 32'h0,        O,   Z, 32'h4,       O, 32'h100093,  32'h4,      Z, 32'd1});
        vq.push_back('{Z, 32'h0,     Z, Z, 32'h0,        Z,   O, 32'h8,       Z, 32'h100093,  32'h4,      Z, 32'd2});
        vq.push_back('{Z, 32'h0,     O, Z, 32'h0,        Z,   O, 32'h8,       Z, 32'h100093,  32'h4,      Z, 32'd2});
        vq.push_back('{O, 32'h100,   Z, Z, 32'h0,        Z,   Z, 32'h8,       Z, 32'h100093,  32'h4,      Z, 32'd2});
        vq.push_back('{Z, 32'h0,     Z, O, 32'hdeadbeef, Z,   Z, 32'h100,     Z, 32'h100093,  32'h4,      Z, 32'd2});
        vq.push_back('{Z, 32'h0,     O, Z, 32'h0,        Z,   O, 32'h100,     Z, 32'h100093,  32'h4,      Z, 32'd2});
        vq.push_back('{Z, 32'h0,     Z, O, 32'h200113,   Z,   Z, 32'h100,     Z, 32'h100093,  32'h4,      Z, 32'd2});
        vq.push_back('{Z, 32'h102,   Z, Z, 32'h0,        O,   Z, 32'h100,     O, 32'h200113,  32'h100,    Z, 32'd2});
        vq.push_back('{O, 32'h200,   Z, Z, 32'h0,        Z,   O, 32'h100,     Z, 32'h200113,  32'h100,    O, 32'd3});
        vq.push_back('{O, 32'h300,   O, Z, 32'h0,        Z,   O, 32'h200,     Z, 32'h200113,  32'h100,    Z, 32'd3});
        vq.push_back('{Z, 32'h0,     Z, O, 32'hbadbad,   Z,   Z, 32'h300,     Z, 32'h200113,  32'h100,    Z, 32'd3});
        vq.push_back('{Z, 32'h0,     O, Z, 32'h0,        Z,   O, 32'h300,     Z, 32'h200113,  32'h100,    Z, 32'd3});
        vq.push_back('{O, 32'h400,   Z, O, 32'hcafe,     Z,   Z, 32'h300,     Z, 32'h200113,  32'h100,    Z, 32'd3});
        vq.push_back('{Z, 32'h0,     O, Z, 32'h0,        Z,   O, 32'h400,     Z, 32'h200113,  32'h100,    Z, 32'd3});
        vq.push_back('{Z, 32'h0,     Z, O, 32'h300193,   Z,   Z, 32'h400,     Z, 32'h200113,  32'h100,    Z, 32'd3});
        vq.push_back('{O, 32'h500,   Z, Z, 32'h0,        O,   Z, 32'h400,     O, 32'h300193,  32'h400,    Z, 32'd3});
        vq.push_back('{Z, 32'h0,     Z, Z, 32'h0,        Z,   O, 32'h500,     Z, 32'h300193,  32'h400,    Z, 32'd3});

        repeat (2) @(negedge clk);
        chk_all("reset", Z, 32'h0, Z, 32'h0, 32'h0, Z, 32'd0);
        rst_n = 1'b1;
        foreach (vq[i]) begin
            flush = vq[i].f; npc = vq[i].npc; imem_gnt = vq[i].gnt;
            imem_rvalid = vq[i].rv; imem_rdata = vq[i].rdata; id_ready = vq[i].rdy;
            #1;
            chk_all($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_val,
                    vq[i].e_inst, vq[i].e_ipc, vq[i].e_mis, vq[i].e_cnt);
            @(negedge clk);
        end

        // reset asserted mid-WAIT, stale rvalid during and after reset
        flush = 1'b0; npc = '0; id_ready = 1'b0; imem_rvalid = 1'b0;
        imem_gnt = 1'b1;
        #1 chk_all("rst_req", O, 32'h500, Z, 32'h300193, 32'h400, Z, 32'd3);
        @(negedge clk);
        imem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all("rst_async", Z, 32'h0, Z, 32'h0, 32'h0, Z, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h5a5a5a5a;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; flush = 1'b1; npc = 32'h700;
        #1 chk_all("rst_idle", Z, 32'h0, Z, 32'h0, 32'h0, Z, 32'd0);
        @(negedge clk);
        flush = 1'b0; npc = '0;
        #1 chk_all("rst_refetch", O, 32'h0, Z, 32'h0, 32'h0, Z, 32'd0);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rdata = 32'h13;
        #1 chk_all("rst_wait", Z, 32'h0, Z, 32'h0, 32'h0, Z, 32'd0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1 chk_all("rst_valid", Z, 32'h0, O, 32'h13, 32'h0, Z, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The parameter RESET_PC SHALL default to 32'h0000_0000 and set the first fetch address after reset.
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state changes on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide, and is the asynchronous, active-low reset.
REQ-004 Port npc SHALL be an input, 32 bits wide, carrying the next-PC value from next-PC logic for the currently held instruction.
REQ-005 Port flush SHALL be an input, 1 bit wide; it discards the held or in-flight instruction and loads npc.
REQ-006 Port pc_out SHALL be an output, 32 bits wide, carrying the current PC fed to next-PC logic.
REQ-007 The instruction-memory request ports SHALL be: imem_req output 1 bit; imem_addr output 32 bits; imem_gnt input 1 bit.
REQ-008 The instruction-memory response ports SHALL be: imem_rvalid input 1 bit; imem_rdata input 32 bits.
REQ-009 The decode-side ports SHALL be: inst_valid output 1 bit; inst output 32 bits; inst_pc output 32 bits; id_ready input 1 bit.
REQ-010 Port misalign SHALL be an output, 1 bit wide, asserted as a one-cycle pulse when npc[1:0] is not 2'b00 at a PC load.
REQ-011 Port retire_cnt SHALL be an output, 32 bits wide, counting instructions accepted by decode.

Function
REQ-012 The FSM SHALL have four states: IDLE, REQ, WAIT and VALID.
REQ-013 IDLE SHALL move to REQ on the first clock after reset deassertion.
REQ-014 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc_out; when imem_gnt=1 the FSM moves to WAIT.
REQ-015 At most one request SHALL be outstanding at a time; imem_rvalid arrives no earlier than one cycle after the grant.
REQ-016 In WAIT, on imem_rvalid=1 the unit SHALL capture imem_rdata into inst, set inst_pc=pc_out and move to VALID, unless the drop flag is set.
REQ-017 In VALID, inst_valid SHALL be 1; when id_ready=1 the unit loads pc_out<=npc, increments retire_cnt (wrapping at 2^32) and returns to REQ.
REQ-018 imem_addr SHALL stay stable while imem_req=1 and no grant has occurred, except on flush.
REQ-019 A flush in REQ without a grant SHALL load pc_out<=npc and keep the FSM in REQ.
REQ-020 A flush in REQ with a grant in the same cycle SHALL load pc_out<=npc, set drop and move to WAIT.
REQ-021 A flush in WAIT SHALL load pc_out<=npc and set drop.
REQ-022 A response arriving while drop=1 SHALL be discarded, SHALL clear drop, and SHALL move the FSM to REQ.
REQ-023 A flush in VALID SHALL discard inst (inst_valid=0 next cycle), load pc_out<=npc, move to REQ and leave retire_cnt unchanged.
REQ-024 flush SHALL have priority over id_ready; flush in IDLE SHALL be ignored.
REQ-025 Simultaneous flush and imem_rvalid in WAIT SHALL discard the response and move to REQ with the new PC.
REQ-026 On every PC load, pc_out SHALL become {npc[31:2],2'b00}, and misalign SHALL pulse if npc[1:0]!=0.
REQ-027 Fetch latency SHALL be 1 REQ cycle plus memory latency; a zero-wait memory gives one instruction per 3 cycles.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately set state=IDLE, pc_out=RESET_PC, drop=0 and retire_cnt=0.
REQ-029 Asserting rst_n=0 SHALL also immediately set imem_req=0, inst_valid=0, inst=0, inst_pc=0 and misalign=0.
REQ-030 A reset during WAIT SHALL abandon the outstanding response, and no stale rvalid after reset SHALL be captured.

Structure
REQ-031 The FSM state encoding and RESET_PC default SHALL live in the shared package alongside the existing opcode defines.
REQ-032 The block SHALL be a single module with no sub-modules; it instantiates none of the next-PC logic.

Verification
REQ-033 Reset release, gnt=1, rvalid the next cycle with data 32'h00000013, id_ready=1 SHALL give imem_addr=0 and then inst=32'h13 with inst_pc=0.
REQ-034 With npc=32'h4 and id_ready=1 the next fetch SHALL be at addr 4, and retire_cnt SHALL read 1 then 2.
REQ-035 id_ready held at 0 for 5 cycles in VALID SHALL keep inst_valid=1, keep inst stable and issue no new imem_req.
REQ-036 A flush in WAIT with npc=32'h100 SHALL discard the late rvalid and produce the next request at 32'h100 with inst_valid never set for the old data.
REQ-037 npc=32'h102 on accept SHALL pulse misalign for one cycle and give a next fetch address of 32'h100.
REQ-038 rst_n pulled low mid-WAIT followed by a stale rvalid SHALL not capture that data, and fetch SHALL restart at RESET_PC.
